// File: rtl/spi_receiver.sv
// SPI receiver smoke block: an internal generator repeatedly sends FRAME_BYTE over SCLK/MOSI/CS_N,
// and the receiver decodes each byte into a command that sets, clears or holds a status flag.
module spi_receiver #(
  parameter int unsigned CLK_DIV    = 2,
  parameter int unsigned IDLE_GAP   = 4,
  parameter logic [7:0]  FRAME_BYTE = 8'h41
) (
  input  logic clk_i,
  input  logic rst_i,
  output logic output__
);

  localparam int unsigned GapW = (IDLE_GAP > 1) ? $clog2(IDLE_GAP) : 1;
  localparam int unsigned SubW = $clog2(2 * CLK_DIV);

  typedef enum logic {GenGap, GenFrame} gen_e;
  typedef enum logic [1:0] {RxIdle, RxReceiving, RxDone} rx_e;
  typedef enum logic [1:0] {CmdNop, CmdSet, CmdClear, CmdInvalid} cmd_e;

  gen_e            gen_q, gen_d;
  logic [GapW-1:0] gap_cnt_q, gap_cnt_d;
  logic [2:0]      bit_idx_q, bit_idx_d;
  logic [SubW-1:0] sub_cnt_q, sub_cnt_d;

  logic sclk, mosi, cs_n;
  logic sclk_prev_q;
  logic sclk_rise;

  rx_e        rx_q, rx_d;
  logic [2:0] count_q, count_d;
  logic [7:0] shift_q, shift_d;

  cmd_e       cmd_tag;
  logic [5:0] cmd_val;
  logic       flag_q, flag_d;

  // Generator
  always_comb begin
    gen_d     = gen_q;
    gap_cnt_d = gap_cnt_q;
    bit_idx_d = bit_idx_q;
    sub_cnt_d = sub_cnt_q;
    unique case (gen_q)
      GenGap: begin
        if (gap_cnt_q == GapW'(IDLE_GAP - 1)) begin
          gen_d     = GenFrame;
          gap_cnt_d = '0;
          bit_idx_d = '0;
          sub_cnt_d = '0;
        end else begin
          gap_cnt_d = gap_cnt_q + GapW'(1);
        end
      end
      GenFrame: begin
        if (sub_cnt_q == SubW'(2 * CLK_DIV - 1)) begin
          sub_cnt_d = '0;
          if (bit_idx_q == 3'd7) begin
            gen_d     = GenGap;
            gap_cnt_d = '0;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          sub_cnt_d = sub_cnt_q + SubW'(1);
        end
      end
      default: gen_d = GenGap;
    endcase
  end

  assign cs_n      = (gen_q != GenFrame);
  assign sclk      = (gen_q == GenFrame) && (sub_cnt_q >= SubW'(CLK_DIV));
  assign mosi      = (gen_q == GenFrame) ? FRAME_BYTE[3'd7 - bit_idx_q] : 1'b0;
  assign sclk_rise = sclk & ~sclk_prev_q;

  // Receiver; in RxDone the shift register holds the completed byte
  always_comb begin
    rx_d    = rx_q;
    count_d = count_q;
    shift_d = shift_q;
    unique case (rx_q)
      RxIdle: begin
        if (!cs_n && sclk_rise) begin
          rx_d    = RxReceiving;
          count_d = 3'd1;
          shift_d = {7'b0, mosi};
        end
      end
      RxReceiving: begin
        if (cs_n) begin
          rx_d = RxIdle;
        end else if (sclk_rise) begin
          shift_d = {shift_q[6:0], mosi};
          if (count_q == 3'd7) begin
            rx_d = RxDone;
          end else begin
            count_d = count_q + 3'd1;
          end
        end
      end
      RxDone:  rx_d = RxIdle;
      default: rx_d = RxIdle;
    endcase
  end

  always_comb begin
    cmd_tag = CmdNop;
    cmd_val = '0;
    unique case (shift_q[7:6])
      2'b00: cmd_tag = CmdNop;
      2'b01: begin
        cmd_tag = CmdSet;
        cmd_val = shift_q[5:0];
      end
      2'b10: cmd_tag = CmdClear;
      2'b11: cmd_tag = CmdInvalid;
      default: cmd_tag = CmdNop;
    endcase
  end

  always_comb begin
    flag_d = flag_q;
    if (rx_q == RxDone) begin
      unique case (cmd_tag)
        CmdSet:   flag_d = (cmd_val != 6'd0);
        CmdClear: flag_d = 1'b0;
        default:  flag_d = flag_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      gen_q       <= GenGap;
      gap_cnt_q   <= '0;
      bit_idx_q   <= '0;
      sub_cnt_q   <= '0;
      sclk_prev_q <= 1'b0;
      rx_q        <= RxIdle;
      count_q     <= '0;
      shift_q     <= '0;
      flag_q      <= 1'b0;
    end else begin
      gen_q       <= gen_d;
      gap_cnt_q   <= gap_cnt_d;
      bit_idx_q   <= bit_idx_d;
      sub_cnt_q   <= sub_cnt_d;
      sclk_prev_q <= sclk;
      rx_q        <= rx_d;
      count_q     <= count_d;
      shift_q     <= shift_d;
      flag_q      <= flag_d;
    end
  end

  assign output__ = flag_q;

endmodule

// File: tb/tb_spi_receiver.sv
// Bench for spi_receiver: several parameterisations share one clock and reset; a frame-timing
// reference model pushes expected flags into a queue that a negedge monitor pops and compares.
module tb_spi_receiver;

  localparam int NDut = 5;
  localparam int NCyc = 3000;

  logic            clk = 1'b0;
  logic            rst;
  logic [NDut-1:0] flag;

  int unsigned cdiv [NDut] = '{2, 2, 2, 2, 1};
  int unsigned gap  [NDut] = '{4, 4, 4, 4, 1};
  logic [7:0]  fbyte[NDut] = '{8'h41, 8'h80, 8'h40, 8'hC5, 8'h7F};

  logic [NDut-1:0] expq[$];
  int checks = 0;
  int errors = 0;
  int mon_cyc = 0;

  always #5 clk = ~clk;

  spi_receiver #(.CLK_DIV(2), .IDLE_GAP(4), .FRAME_BYTE(8'h41)) u_d0 (
    .clk_i(clk), .rst_i(rst), .output__(flag[0]));
  spi_receiver #(.CLK_DIV(2), .IDLE_GAP(4), .FRAME_BYTE(8'h80)) u_d1 (
    .clk_i(clk), .rst_i(rst), .output__(flag[1]));
  spi_receiver #(.CLK_DIV(2), .IDLE_GAP(4), .FRAME_BYTE(8'h40)) u_d2 (
    .clk_i(clk), .rst_i(rst), .output__(flag[2]));
  spi_receiver #(.CLK_DIV(2), .IDLE_GAP(4), .FRAME_BYTE(8'hC5)) u_d3 (
    .clk_i(clk), .rst_i(rst), .output__(flag[3]));
  spi_receiver #(.CLK_DIV(1), .IDLE_GAP(1), .FRAME_BYTE(8'h7F)) u_d4 (
    .clk_i(clk), .rst_i(rst), .output__(flag[4]));

  // Effect of one received byte on the flag, straight from the command table
  function automatic logic apply_cmd(input logic [7:0] b, input logic cur);
    logic [1:0] top;
    top = b[7:6];
    case (top)
      2'b01:   return (b[5:0] != 6'd0);
      2'b10:   return 1'b0;
      default: return cur;
    endcase
  endfunction

  // Driver + reference model. t = cycles since reset release; the 8th SCLK rise of frame k
  // is at t = gap + 15*div + k*(gap + 16*div), Done follows one cycle later.
  initial begin
    logic [NDut-1:0] mflag;
    int unsigned     t;
    int unsigned     r, p;
    mflag = '0;
    t     = 0;
    rst   = 1'b1;
    for (int cyc = 0; cyc < NCyc; cyc++) begin
      if (cyc == 0 || cyc == 300 || cyc == 356) rst = 1'b1;
      else if (cyc < 400) rst = 1'b0;
      else rst = ($urandom_range(0, 119) == 0);
      @(posedge clk);
      if (rst) begin
        mflag = '0;
        t     = 0;
      end else begin
        for (int d = 0; d < NDut; d++) begin
          r = gap[d] + 15 * cdiv[d];
          p = gap[d] + 16 * cdiv[d];
          if (t >= r + 1 && ((t - r - 1) % p) == 0) mflag[d] = apply_cmd(fbyte[d], mflag[d]);
        end
        t++;
      end
      expq.push_back(mflag);
      #1;
    end
    @(negedge clk);
    #1;
    checks++;
    if (expq.size() != 0) begin
      errors++;
      $display("FAIL queue_drain: %0d entries left, required 0", expq.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Monitor: the flag is presented every cycle, so every queued entry is compared
  initial begin
    logic [NDut-1:0] exp_v;
    forever begin
      @(negedge clk);
      if (expq.size() > 0) begin
        exp_v = expq.pop_front();
        for (int d = 0; d < NDut; d++) begin
          checks++;
          if (flag[d] !== exp_v[d]) begin
            errors++;
            $display("FAIL flag_dut%0d (byte %h) cycle %0d: got %b required %b",
                     d, fbyte[d], mon_cyc, flag[d], exp_v[d]);
          end
        end
        mon_cyc++;
      end
    end
  end

endmodule
